// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared constants, field accessors and FSM encoding for the pipeline issue controller.
package pipe_pkg;

    localparam logic [1:0] K1     = 2'b01;
    localparam logic [2:0] OP_ORI = 3'b111;

    localparam int unsigned RA_HI = 7;
    localparam int unsigned RA_LO = 6;
    localparam int unsigned RB_HI = 5;
    localparam int unsigned RB_LO = 4;
    localparam int unsigned OP_HI = 2;
    localparam int unsigned OP_LO = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [1:0] inst_ra(input logic [7:0] inst);
        return inst[RA_HI:RA_LO];
    endfunction

    function automatic logic [1:0] inst_rb(input logic [7:0] inst);
        return inst[RB_HI:RB_LO];
    endfunction

    function automatic logic [2:0] inst_op(input logic [7:0] inst);
        return inst[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Decode/execute boundary signals of the issue controller.
interface pipe_issue_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       dec_inst;
    logic             dec_valid;
    logic             br_taken;
    logic             mem_busy;
    logic             stall_fetch;
    logic             flush;
    logic             ex_valid;
    logic [7:0]       ex_inst;
    logic             wb_valid;
    logic [7:0]       wb_inst;
    logic [CNT_W-1:0] perf_cnt;

    modport master (
        output dec_inst, dec_valid, br_taken, mem_busy,
        input  stall_fetch, flush, ex_valid, ex_inst, wb_valid, wb_inst, perf_cnt
    );

    modport slave (
        input  dec_inst, dec_valid, br_taken, mem_busy,
        output stall_fetch, flush, ex_valid, ex_inst, wb_valid, wb_inst, perf_cnt
    );
endinterface

// File: rtl/pipe_issue_ctrl_hazard_match.sv
// Register hazard test of a decoded instruction against one in-flight stage.
module hazard_match
    import pipe_pkg::*;
(
    input  logic [7:0] d_i,
    input  logic [7:0] s_i,
    input  logic       s_valid_i,
    output logic       hz_o
);
    logic d_ori;
    logic s_ori;
    logic s_ra_k1;
    logic d_uses_k1;
    logic unused_bits;

    assign d_ori       = (inst_op(d_i) == OP_ORI);
    assign s_ori       = (inst_op(s_i) == OP_ORI);
    assign s_ra_k1     = (inst_ra(s_i) == K1);
    assign d_uses_k1   = (inst_ra(d_i) == K1) || (inst_rb(d_i) == K1);
    assign unused_bits = ^{d_i[3], s_i[5:3]};

    always_comb begin
        hz_o = 1'b0;
        if (s_valid_i) begin
            // ORI writes K1 implicitly, so K1 users must also wait on any ORI
            if (d_ori || d_uses_k1) begin
                hz_o = s_ra_k1 || s_ori;
            end else begin
                hz_o = (inst_ra(d_i) == inst_ra(s_i)) || (inst_rb(d_i) == inst_ra(s_i));
            end
        end
    end
endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue/stall sequencer owning the EX and WB stage registers of the 8-bit pipeline.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic         clock,
    input logic         reset,
    pipe_issue_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic             ex_valid_q, ex_valid_d;
    logic [7:0]       ex_inst_q, ex_inst_d;
    logic             wb_valid_q, wb_valid_d;
    logic [7:0]       wb_inst_q, wb_inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hz_ex;
    logic hz_wb;
    logic hz;
    logic count_bubble;
    logic stall_fetch;
    logic flush;

    hazard_match u_hz_ex (
        .d_i      (bus.dec_inst),
        .s_i      (ex_inst_q),
        .s_valid_i(ex_valid_q),
        .hz_o     (hz_ex)
    );

    hazard_match u_hz_wb (
        .d_i      (bus.dec_inst),
        .s_i      (wb_inst_q),
        .s_valid_i(wb_valid_q),
        .hz_o     (hz_wb)
    );

    assign hz = bus.dec_valid && (hz_ex || hz_wb);

    always_comb begin
        state_d      = state_q;
        ex_valid_d   = ex_valid_q;
        ex_inst_d    = ex_inst_q;
        wb_valid_d   = wb_valid_q;
        wb_inst_d    = wb_inst_q;
        cnt_d        = cnt_q;
        count_bubble = 1'b0;
        stall_fetch  = 1'b0;
        flush        = 1'b0;

        if (reset || bus.mem_busy) begin
            stall_fetch = 1'b1;
        end else begin
            wb_valid_d = ex_valid_q;
            wb_inst_d  = ex_inst_q;
            ex_valid_d = 1'b0;
            ex_inst_d  = '0;
            unique case (state_q)
                ST_FLUSH: begin
                    flush        = 1'b1;
                    count_bubble = 1'b1;
                    state_d      = ST_RUN;
                end
                default: begin
                    if (bus.br_taken) begin
                        flush        = 1'b1;
                        count_bubble = 1'b1;
                        state_d      = ST_FLUSH;
                    end else if (hz) begin
                        stall_fetch  = 1'b1;
                        count_bubble = 1'b1;
                        state_d      = ST_STALL;
                    end else begin
                        ex_valid_d = bus.dec_valid;
                        ex_inst_d  = bus.dec_valid ? bus.dec_inst : '0;
                        state_d    = ST_RUN;
                    end
                end
            endcase
            if (count_bubble && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
            ex_inst_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_inst_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_inst_q  <= ex_inst_d;
            wb_valid_q <= wb_valid_d;
            wb_inst_q  <= wb_inst_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.stall_fetch = stall_fetch;
    assign bus.flush       = flush;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_inst     = ex_inst_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_inst     = wb_inst_q;
    assign bus.perf_cnt    = cnt_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed and randomized checks of pipe_issue_ctrl against a behavioural pipeline model.
module tb_pipe_issue_ctrl;
    localparam int unsigned CW = 4;

    logic clock;
    logic reset;

    pipe_issue_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_issue_ctrl #(.CNT_W(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: the two in-flight slots plus a "next slot is wrong-path" flag.
    logic       m_exv, m_wbv;
    logic [7:0] m_exi, m_wbi;
    bit         m_squash_next;
    int         m_cnt;

    function automatic bit ref_hz(input logic [7:0] d, input logic sv, input logic [7:0] s);
        if (!sv) return 1'b0;
        if (d[2:0] == 3'b111) return (s[7:6] == 2'b01) || (s[2:0] == 3'b111);
        if (d[7:6] == 2'b01 || d[5:4] == 2'b01) return (s[2:0] == 3'b111) || (s[7:6] == 2'b01);
        return (d[7:6] == s[7:6]) || (d[5:4] == s[7:6]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then state after the edge.
    task automatic step(input logic [7:0] inst, input logic v, input logic br,
                        input logic mb, input logic rst);
        bit         e_sf, e_fl, bubble_cnt;
        logic       n_exv;
        logic [7:0] n_exi;
        bus.dec_inst  = inst;
        bus.dec_valid = v;
        bus.br_taken  = br;
        bus.mem_busy  = mb;
        reset         = rst;
        #1;
        e_sf = 1'b0; e_fl = 1'b0; bubble_cnt = 1'b0;
        n_exv = 1'b0; n_exi = 8'h00;
        if (rst || mb) begin
            e_sf = 1'b1;
        end else if (m_squash_next) begin
            e_fl = 1'b1; bubble_cnt = 1'b1;
        end else if (br) begin
            e_fl = 1'b1; bubble_cnt = 1'b1;
        end else if (v && (ref_hz(inst, m_exv, m_exi) || ref_hz(inst, m_wbv, m_wbi))) begin
            e_sf = 1'b1; bubble_cnt = 1'b1;
        end else begin
            n_exv = v; n_exi = v ? inst : 8'h00;
        end
        chk("stall_fetch", 32'(bus.stall_fetch), 32'(e_sf));
        chk("flush", 32'(bus.flush), 32'(e_fl));

        if (rst) begin
            m_exv = 0; m_exi = 0; m_wbv = 0; m_wbi = 0; m_squash_next = 0; m_cnt = 0;
        end else if (!mb) begin
            m_squash_next = !m_squash_next && br;
            m_wbv = m_exv; m_wbi = m_exi;
            m_exv = n_exv; m_exi = n_exi;
            if (bubble_cnt && m_cnt < (2 ** CW) - 1) m_cnt++;
        end

        @(posedge clock);
        #1;
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_exv));
        chk("ex_inst", 32'(bus.ex_inst), 32'(m_exi));
        chk("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
        chk("wb_inst", 32'(bus.wb_inst), 32'(m_wbi));
        chk("perf_cnt", 32'(bus.perf_cnt), 32'(m_cnt));
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.dec_inst = '0; bus.dec_valid = 0; bus.br_taken = 0; bus.mem_busy = 0;
        reset = 1'b1;
        m_exv = 0; m_exi = 0; m_wbv = 0; m_wbi = 0; m_squash_next = 0; m_cnt = 0;
        @(negedge clock);

        step(8'h00, 0, 0, 0, 1);
        step(8'h00, 0, 0, 0, 1);
        chk("reset_perf", 32'(bus.perf_cnt), 32'd0);

        // Independent back-to-back issue
        step(8'b00_01_0_000, 1, 0, 0, 0);
        step(8'b10_11_0_000, 1, 0, 0, 0);
        chk("nohz_ex", 32'(bus.ex_inst), 32'h000000B0);
        chk("nohz_wb", 32'(bus.wb_inst), 32'h00000010);
        idle(2);
        chk("nohz_perf", 32'(bus.perf_cnt), 32'd0);

        // RAW hazard held through EX and WB
        step(8'b10_00_0_000, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(8'b00_10_0_001, 1, 0, 0, 0);
        chk("raw_ex", 32'(bus.ex_inst), 32'h00000021);
        chk("raw_perf", 32'(bus.perf_cnt), 32'd2);
        idle(2);

        // ORI chain
        step(8'b00_00_0_111, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(8'b11_11_0_111, 1, 0, 0, 0);
        chk("ori_perf", 32'(bus.perf_cnt), 32'd4);
        idle(2);

        // Taken branch squashes two slots
        step(8'h44, 1, 1, 0, 0);
        step(8'h88, 1, 0, 0, 0);
        chk("br_exv", 32'(bus.ex_valid), 32'd0);
        chk("br_perf", 32'(bus.perf_cnt), 32'd6);
        idle(2);

        // Freeze during a stall, then the stall resumes
        step(8'b10_00_0_000, 1, 0, 0, 0);
        step(8'b00_10_0_001, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(8'b00_10_0_001, 1, 1, 1, 0);
        step(8'b00_10_0_001, 1, 0, 0, 0);
        step(8'b00_10_0_001, 1, 0, 0, 0);
        chk("frz_perf", 32'(bus.perf_cnt), 32'd8);
        idle(2);

        // Reset while a flush is pending
        step(8'h11, 1, 1, 0, 0);
        step(8'h22, 1, 0, 0, 1);
        step(8'h00, 0, 0, 0, 0);
        chk("rstfl_perf", 32'(bus.perf_cnt), 32'd0);

        // Randomized traffic with a small register file so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

Issue and stall sequencer for the 8-bit pipelined processor. It sits between decode and execute and owns the two in-flight stage registers, execute (EX) and writeback (WB). Each cycle it checks the decoded instruction for register hazards against EX and WB, and either issues it or inserts a bubble. It also squashes wrong-path instructions after a taken branch and freezes the pipe while memory is busy.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall/flush performance counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- dec_inst  in  8  decoded instruction: rA=[7:6], rB=[5:4], op=[2:0]
- dec_valid  in  1  dec_inst is a real instruction
- br_taken  in  1  instruction in EX is a taken branch; sampled only when mem_busy=0
- mem_busy  in  1  freeze request from the memory stage
- stall_fetch  out  1  hold fetch/decode this cycle (combinational)
- flush  out  1  wrong-path squash active this cycle (combinational)
- ex_valid, ex_inst  out  1, 8  EX stage register
- wb_valid, wb_inst  out  1, 8  WB stage register
- perf_cnt  out  CNT_W  bubbles inserted; saturates at all-ones

## Operation
Hazard rule for D=dec_inst against a stage S. Only stages with valid=1 participate. ORI is op=3'b111 and implicitly uses K1=2'b01.
- D.op==ORI: hazard if S.rA==K1 or S.op==ORI
- else if D.rA==K1 or D.rB==K1: hazard if S.op==ORI or S.rA==K1
- else: hazard if D.rA==S.rA or D.rB==S.rA
- hz = dec_valid & (hazard(EX) | hazard(WB))

FSM states: RUN, STALL, FLUSH. Priority: reset > mem_busy > br_taken > hz.
- mem_busy=1: no register, state or counter changes; stall_fetch=1; flush=0.
- br_taken=1 in RUN or STALL: discard dec_inst, issue a bubble, flush=1, stall_fetch=0, go to FLUSH.
- br_taken=1 in FLUSH: ignored.
- FLUSH: discard dec_inst, issue a bubble, flush=1, go to RUN.
- RUN/STALL with hz=1: issue a bubble, stall_fetch=1, go to (or stay in) STALL.
- RUN/STALL with hz=0: issue dec_inst (ex_valid<=dec_valid), stall_fetch=0, go to RUN.
- Advance, i.e. any cycle without mem_busy: WB<=EX; EX<=issued instruction or bubble. A bubble is valid=0, inst=8'h00.
- perf_cnt increments on every bubble issued for a hazard or a flush. A bubble caused by dec_valid=0 does not count.

## Timing
- Reset values: state RUN; ex_valid, wb_valid 0; ex_inst, wb_inst 8'h00; perf_cnt 0.
- While reset is high: stall_fetch=1 and flush=0.
- Issue latency: dec_inst accepted at edge t appears on ex_inst after edge t, and on wb_inst one cycle later.
- Maximum hazard stall is 2 cycles, because the producer leaves WB after two advances. mem_busy extends a stall without limit.
- A flush squashes exactly 2 decode slots: the br_taken cycle and the following cycle.
- Reset mid-stall or mid-flush: all state clears on that edge. No pending flush survives reset.
- br_taken and hz in the same cycle: flush wins, and the hazard is not counted separately (one bubble counted).

## Structure
- Shared package `pipe_pkg`: K1=2'b01, OP_ORI=3'b111, field index constants, and FSM state encoding.
- Sub-module `hazard_match`: combinational; inputs D, S and S.valid; output is the hazard bit. Instantiate it twice, once for EX and once for WB.
- The top level holds the FSM, stage registers and counter.

## Test plan
- No hazard: issue 8'b00_01_0_000, then 8'b10_11_0_000 back-to-back, with K1 not involved in the second. Required: both issued on consecutive cycles, stall_fetch stays 0, perf_cnt=0.
- RAW through both stages: issue 8'b10_00_0_000, then decode 8'b00_10_0_001. Required: 2 bubbles, stall_fetch high for 2 cycles, second instruction reaches ex_inst on the 3rd cycle, perf_cnt=2.
- ORI chain: issue 8'b00_00_0_111, then decode 8'b11_11_0_111. Required: hazard, 2 bubbles.
- Taken branch: br_taken=1 with dec_valid=1, then a valid instruction on the next cycle. Required: flush=1 for 2 cycles, neither instruction reaches EX, perf_cnt += 2.
- Freeze: mem_busy=1 for 3 cycles during STALL. Required: ex_inst, wb_inst, state and perf_cnt unchanged, stall_fetch=1; the stall resumes afterward.
- Reset asserted in FLUSH. Required: next cycle is RUN, all valids 0, perf_cnt=0, flush=0.
